// File: rtl/led_bit_encoder.sv
// WS2812-style single-wire bit encoder: turns write0/write1/reset strobes into timed dout waveforms.
// Optional macro LED_BIT_COUNT_EN adds a saturating count of data bits sent since the last latch code.
module led_bit_encoder #(
    parameter int unsigned T0H   = 20,
    parameter int unsigned T0L   = 42,
    parameter int unsigned T1H   = 40,
    parameter int unsigned T1L   = 22,
    parameter int unsigned T_RST = 2500
) (
    input  logic        clk_50Mhz,
    input  logic        rst_n,
    input  logic        write0,
    input  logic        write1,
    input  logic        reset,
    output logic        ready,
    output logic        dout,
    output logic        cmd_err,
    output logic [15:0] bit_count
);

    localparam logic [15:0] T0H_M1   = 16'(T0H - 1);
    localparam logic [15:0] T0L_M1   = 16'(T0L - 1);
    localparam logic [15:0] T1H_M1   = 16'(T1H - 1);
    localparam logic [15:0] T1L_M1   = 16'(T1L - 1);
    localparam logic [15:0] T_RST_M1 = 16'(T_RST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        RST  = 2'd3
    } state_t;

    state_t      state_r;
    logic [15:0] count_r;
    logic        bit_sel_r;
    logic        dout_r;
    logic        ready_r;
    logic        err_r;
    logic        w0_hist_r;
    logic        w1_hist_r;
    logic        rst_hist_r;

    logic        new_w0_s;
    logic        new_w1_s;
    logic        new_rst_s;
    logic        multi_s;

    // Rising-edge detection against last cycle's strobe levels
    always_comb begin
        new_w0_s  = write0 & ~w0_hist_r;
        new_w1_s  = write1 & ~w1_hist_r;
        new_rst_s = reset  & ~rst_hist_r;
        multi_s   = (new_w0_s & new_w1_s) | (new_w0_s & new_rst_s) | (new_w1_s & new_rst_s);
    end

    // Strobe history, updated every cycle regardless of state
    always_ff @(posedge clk_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            w0_hist_r  <= 1'b0;
            w1_hist_r  <= 1'b0;
            rst_hist_r <= 1'b0;
        end else begin
            w0_hist_r  <= write0;
            w1_hist_r  <= write1;
            rst_hist_r <= reset;
        end
    end

    // Waveform FSM; dout/ready/cmd_err are registered alongside the state
    always_ff @(posedge clk_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            count_r   <= 16'd0;
            bit_sel_r <= 1'b0;
            dout_r    <= 1'b0;
            ready_r   <= 1'b1;
            err_r     <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (new_rst_s) begin
                        state_r <= RST;
                        count_r <= T_RST_M1;
                        dout_r  <= 1'b0;
                        ready_r <= 1'b0;
                        err_r   <= multi_s;
                    end else if (new_w1_s) begin
                        state_r   <= HIGH;
                        count_r   <= T1H_M1;
                        bit_sel_r <= 1'b1;
                        dout_r    <= 1'b1;
                        ready_r   <= 1'b0;
                        err_r     <= multi_s;
                    end else if (new_w0_s) begin
                        state_r   <= HIGH;
                        count_r   <= T0H_M1;
                        bit_sel_r <= 1'b0;
                        dout_r    <= 1'b1;
                        ready_r   <= 1'b0;
                    end else begin
                        dout_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                HIGH: begin
                    if (count_r == 16'd0) begin
                        state_r <= LOW;
                        count_r <= bit_sel_r ? T1L_M1 : T0L_M1;
                        dout_r  <= 1'b0;
                    end else begin
                        count_r <= count_r - 16'd1;
                    end
                end
                LOW, RST: begin
                    if (count_r == 16'd0) begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        count_r <= count_r - 16'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    count_r <= 16'd0;
                    dout_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign dout    = dout_r;
    assign ready   = ready_r;
    assign cmd_err = err_r;

`ifdef LED_BIT_COUNT_EN
    logic [15:0] bit_cnt_r;

    // Count completed data bits; a completed latch code clears the count
    always_ff @(posedge clk_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= 16'd0;
        end else if (state_r == LOW && count_r == 16'd0 && bit_cnt_r != 16'hFFFF) begin
            bit_cnt_r <= bit_cnt_r + 16'd1;
        end else if (state_r == RST && count_r == 16'd0) begin
            bit_cnt_r <= 16'd0;
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    assign bit_count = bit_cnt_r;
`else
    assign bit_count = 16'd0;
`endif

endmodule

// File: tb/tb_led_bit_encoder.sv
// Scoreboard bench for led_bit_encoder: stimulus queues expected symbol shapes, a monitor measures dout.
module tb_led_bit_encoder;

    logic        clk_50Mhz;
    logic        rst_n;
    logic        write0;
    logic        write1;
    logic        reset;
    logic        ready;
    logic        dout;
    logic        cmd_err;
    logic [15:0] bit_count;

    typedef struct {
        int hi;
        int lo;
        int err;
    } sym_t;

    sym_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   hi_c, lo_c, err_c;
    bit   busy, shape_bad;

    led_bit_encoder dut (
        .clk_50Mhz(clk_50Mhz),
        .rst_n    (rst_n),
        .write0   (write0),
        .write1   (write1),
        .reset    (reset),
        .ready    (ready),
        .dout     (dout),
        .cmd_err  (cmd_err),
        .bit_count(bit_count)
    );

    initial clk_50Mhz = 1'b0;
    always #10 clk_50Mhz = ~clk_50Mhz;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_bits(input int bits);
`ifdef LED_BIT_COUNT_EN
        chk("bit_count", int'(bit_count), bits);
`else
        chk("bit_count", int'(bit_count), bits * 0);
`endif
    endtask

    // Measures each busy period (ready low) and compares its shape with the queue head
    task automatic monitor();
        sym_t e;
        hi_c = 0; lo_c = 0; err_c = 0; busy = 1'b0; shape_bad = 1'b0;
        forever begin
            @(negedge clk_50Mhz);
            if (!rst_n) begin
                hi_c = 0; lo_c = 0; err_c = 0; busy = 1'b0; shape_bad = 1'b0;
            end else begin
                if (cmd_err) err_c++;
                if (!ready) begin
                    busy = 1'b1;
                    if (dout) begin
                        if (lo_c > 0) shape_bad = 1'b1;
                        hi_c++;
                    end else begin
                        lo_c++;
                    end
                end else if (busy) begin
                    if (q.size() == 0) begin
                        chk("unexpected_symbol", hi_c + lo_c, 0);
                    end else begin
                        e = q.pop_front();
                        chk("high_cycles", hi_c, e.hi);
                        chk("low_cycles", lo_c, e.lo);
                        chk("cmd_err_pulses", err_c, e.err);
                        chk("shape_high_then_low", int'(shape_bad), 0);
                    end
                    hi_c = 0; lo_c = 0; err_c = 0; busy = 1'b0; shape_bad = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 5000) begin
            @(posedge clk_50Mhz); #1;
            n++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 expected=1");
        end
    endtask

    // Drive strobes for hold cycles, expect the given symbol, then wait for idle
    task automatic send(input logic w0, input logic w1, input logic rs, input int hold,
                        input int hi, input int lo, input int err, input int bits);
        q.push_back('{hi, lo, err});
        write0 = w0; write1 = w1; reset = rs;
        @(posedge clk_50Mhz); #1;
        chk("first_cycle_dout", int'(dout), (hi > 0) ? 1 : 0);
        chk("first_cycle_ready", int'(ready), 0);
        if (hold > 1) repeat (hold - 1) @(posedge clk_50Mhz);
        #1;
        write0 = 1'b0; write1 = 1'b0; reset = 1'b0;
        wait_ready();
        chk_bits(bits);
    endtask

    task automatic run();
        write0 = 1'b0; write1 = 1'b0; reset = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk_50Mhz); #2;
        chk("rst_dout", int'(dout), 0);
        chk("rst_ready", int'(ready), 1);
        chk("rst_cmd_err", int'(cmd_err), 0);
        chk("rst_bit_count", int'(bit_count), 0);

        // write1 already high as reset releases counts as a new edge
        write1 = 1'b1;
        rst_n  = 1'b1;
        send(1'b0, 1'b1, 1'b0, 4, 40, 22, 0, 1);
        send(1'b1, 1'b0, 1'b0, 4, 20, 42, 0, 2);

        // back-to-back data bits up to 24 total
        for (int i = 0; i < 22; i++) begin
            if (i % 2 == 0) send(1'b0, 1'b1, 1'b0, 1, 40, 22, 0, 3 + i);
            else            send(1'b1, 1'b0, 1'b0, 1, 20, 42, 0, 3 + i);
        end
        send(1'b0, 1'b0, 1'b1, 2, 0, 2500, 0, 0);

        send(1'b1, 1'b1, 1'b0, 3, 40, 22, 1, 1);
        send(1'b0, 1'b1, 1'b1, 3, 0, 2500, 1, 0);

        // write1 pulse during HIGH of a 0 bit must be ignored
        q.push_back('{20, 42, 0});
        write0 = 1'b1;
        repeat (4) @(posedge clk_50Mhz); #1;
        write0 = 1'b0;
        repeat (5) @(posedge clk_50Mhz); #1;
        write1 = 1'b1;
        repeat (3) @(posedge clk_50Mhz); #1;
        write1 = 1'b0;
        wait_ready();
        chk_bits(1);

        // rst_n dropped mid-bit: immediate idle outputs, partial bit abandoned
        write0 = 1'b1;
        @(posedge clk_50Mhz); #1;
        chk("midbit_dout_high", int'(dout), 1);
        repeat (3) @(posedge clk_50Mhz); #1;
        write0 = 1'b0;
        repeat (6) @(posedge clk_50Mhz); #2;
        rst_n = 1'b0;
        #1;
        chk("midbit_rst_dout", int'(dout), 0);
        chk("midbit_rst_ready", int'(ready), 1);
        chk("midbit_rst_cmd_err", int'(cmd_err), 0);
        repeat (2) @(posedge clk_50Mhz); #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk_50Mhz); #1;
        send(1'b1, 1'b0, 1'b0, 4, 20, 42, 0, 1);

        repeat (5) @(posedge clk_50Mhz); #1;
        chk("queue_empty", q.size(), 0);
    endtask

    initial begin
        fork
            monitor();
            run();
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
